// File: rtl/counter_arb_pkg.sv
// counter_arb_pkg: counter mode encodings, arbiter state encoding and terminal counts.
package counter_arb_pkg;
  localparam logic [1:0] MODE_UP3  = 2'b00;
  localparam logic [1:0] MODE_DN1  = 2'b01;
  localparam logic [1:0] MODE_UP1  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;
  localparam logic [3:0] TERM_UP = 4'hF;
  localparam logic [3:0] TERM_DN = 4'h0;
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_t;
endpackage

// File: rtl/counter_arbiter_rr_picker.sv
// rr_picker: first set req bit at or above ptr, wrapping; returns one-hot winner and its index.
module rr_picker #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] win,
  output logic [IDW-1:0]  idx
);
  logic [2*NREQ-1:0] dbl;
  always_comb begin
    dbl = {req, req} >> ptr;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (dbl[k]) idx = IDW'((int'(ptr) + k) % NREQ);
    win = |req ? NREQ'(1) << idx : '0;
  end
endmodule

// File: rtl/counter_arbiter.sv
// counter_arbiter: shares one 4-bit counter among NREQ requesters with load/run/watchdog control.
// Define COUNTER_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module counter_arbiter
  import counter_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int MAX_RUN = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] req_D,
  input  logic [NREQ-1:0]   req_dir,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [NREQ-1:0]   err,
  output logic              busy,
  output logic [IDW-1:0]    owner,
  output logic              cnt_enable,
  output logic [1:0]        cnt_mode,
  output logic [3:0]        cnt_D,
  input  logic [3:0]        cnt_Q,
  input  logic              cnt_rco,
  input  logic              cnt_load
);
  state_t          state;
  logic [7:0]      run_cnt, run_nxt;
  logic            load_wait;
  logic [NREQ-1:0] win;
  logic [IDW-1:0]  win_idx, ptr;
  logic [3:0]      own_d;
  logic            own_dir, own_req, unused_q;
  rr_picker #(.NREQ(NREQ), .IDW(IDW)) u_pick (.req(req), .ptr(ptr), .win(win), .idx(win_idx));
  // completion comes from rco; Q is only observed by the requesters
  assign unused_q   = ^cnt_Q;
  assign own_d      = 4'(req_D >> {owner, 2'b00});
  assign own_dir    = 1'(req_dir >> owner);
  assign own_req    = 1'(req >> owner);
  assign run_nxt    = run_cnt == 8'hFF ? run_cnt : run_cnt + 8'd1;
  assign busy       = state != ST_IDLE;
  assign cnt_enable = state == ST_LOAD || state == ST_RUN;
  assign cnt_mode   = state == ST_LOAD ? MODE_LOAD : state == ST_RUN ? (own_dir ? MODE_UP1 : MODE_DN1) : MODE_UP3;
  assign cnt_D      = state == ST_LOAD ? own_d : 4'h0;
`ifdef COUNTER_ARB_RR_EN
  always_ff @(posedge clk)
    if (reset) ptr <= '0;
    else if (state == ST_DONE || state == ST_ERR) ptr <= owner == IDW'(NREQ - 1) ? '0 : owner + IDW'(1);
`else
  assign ptr = '0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      gnt       <= '0;
      done      <= '0;
      err       <= '0;
      owner     <= '0;
      run_cnt   <= '0;
      load_wait <= 1'b0;
    end else begin
      done <= '0;
      err  <= '0;
      case (state)
        ST_IDLE: if (|req) begin
          state     <= ST_LOAD;
          gnt       <= win;
          owner     <= win_idx;
          run_cnt   <= '0;
          load_wait <= 1'b0;
        end
        ST_LOAD: if (cnt_load) state <= ST_RUN;
          else if (load_wait) begin
            state <= ST_ERR;
            err   <= gnt;
          end else load_wait <= 1'b1;
        ST_RUN: begin
          run_cnt <= run_nxt;
          if (!own_req) begin
            state <= ST_IDLE;
            gnt   <= '0;
          end else if (cnt_rco) begin
            state <= ST_DONE;
            done  <= gnt;
          end else if (run_nxt == 8'(MAX_RUN)) begin
            state <= ST_ERR;
            err   <= gnt;
          end
        end
        ST_DONE, ST_ERR: begin
          state <= ST_IDLE;
          gnt   <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_counter_arbiter.sv
// tb_counter_arbiter: scoreboard bench with a behavioural counter model driven by the arbiter.
`timescale 1ns/1ps
module tb_counter_arbiter;
  import counter_arb_pkg::*;
  localparam int NREQ = 4, IDW = 2, MAX_RUN = 20;
  logic clk = 1'b0, reset = 1'b1;
  logic [NREQ-1:0] req = '0, req_dir = '0;
  logic [4*NREQ-1:0] req_d = '0;
  logic [NREQ-1:0] gnt, done, err, gnt_q;
  logic busy, cnt_enable, cnt_load, cnt_rco;
  logic load_kill = 1'b0, rco_kill = 1'b0;
  logic [IDW-1:0] owner;
  logic [1:0] cnt_mode;
  logic [3:0] cnt_d, q = 4'h0;
  int checks = 0, failures = 0, run_cyc = 0, e, n;
  int exp_gnt[$], exp_len[$];
  logic [2*NREQ-1:0] exp_end[$];
  int order[4];
  always #5 clk = ~clk;
  counter_arbiter #(.NREQ(NREQ), .IDW(IDW), .MAX_RUN(MAX_RUN)) dut (
    .clk(clk), .reset(reset), .req(req), .req_D(req_d), .req_dir(req_dir),
    .gnt(gnt), .done(done), .err(err), .busy(busy), .owner(owner),
    .cnt_enable(cnt_enable), .cnt_mode(cnt_mode), .cnt_D(cnt_d),
    .cnt_Q(q), .cnt_rco(cnt_rco), .cnt_load(cnt_load));
  assign cnt_load = cnt_enable && cnt_mode == MODE_LOAD && !load_kill;
  assign cnt_rco  = !rco_kill && cnt_enable &&
                    ((cnt_mode == MODE_UP1 && q == 4'hF) || (cnt_mode == MODE_DN1 && q == 4'h0));
  always @(posedge clk)
    if (cnt_enable)
      q <= cnt_mode == MODE_LOAD ? cnt_d : cnt_mode == MODE_UP1 ? q + 4'd1 :
           cnt_mode == MODE_DN1 ? q - 4'd1 : q + 4'd3;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (cnt_enable && (cnt_mode == MODE_UP1 || cnt_mode == MODE_DN1)) run_cyc++;
    if (gnt != '0 && gnt_q == '0) begin
      run_cyc = 0;
      if (exp_gnt.size() == 0) check("gnt_unexpected", 32'(gnt), 0);
      else begin
        e = exp_gnt.pop_front();
        check("gnt_order", 32'(gnt), 32'(1) << e);
        check("owner", 32'(owner), e);
      end
    end
    if ((done | err) != '0) begin
      if (exp_end.size() == 0) check("end_unexpected", 32'({done, err}), 0);
      else begin
        check("end_pulse", 32'({done, err}), 32'(exp_end.pop_front()));
        check("run_len", run_cyc, exp_len.pop_front());
      end
    end
    gnt_q = gnt;
  end
  task automatic tick(input int c = 1);
    repeat (c) @(negedge clk);
  endtask
  task automatic drive(input int i, input logic [3:0] d, input logic dir);
    req_d[4*i +: 4] = d;
    req_dir[i] = dir;
    req[i] = 1'b1;
  endtask
  task automatic wait_end(input string tag, output int c);
    c = 0;
    do begin
      tick();
      c++;
    end while ((done | err) == '0 && c < 60);
    check({tag, "_end_seen"}, 32'(|(done | err)), 1);
  endtask
  task automatic push_end(input int i, input logic is_err, input int len);
    exp_end.push_back(is_err ? {NREQ'(0), NREQ'(1) << i} : {NREQ'(1) << i, NREQ'(0)});
    exp_len.push_back(len);
  endtask
  task automatic run_one(input string tag, input int i, input logic [3:0] d, input logic dir,
                         input logic is_err, input int len);
    int c;
    exp_gnt.push_back(i);
    push_end(i, is_err, len);
    drive(i, d, dir);
    tick(2);
    check({tag, "_mode"}, 32'(cnt_mode), load_kill ? MODE_LOAD : dir ? MODE_UP1 : MODE_DN1);
    wait_end(tag, c);
    check({tag, "_cycles"}, c, len == 0 ? 1 : len);
    check({tag, "_end_en"}, 32'(cnt_enable), 0);
    req = '0;
    tick();
    check({tag, "_idle_busy"}, 32'(busy), 0);
    check({tag, "_idle_en"}, 32'(cnt_enable), 0);
    check({tag, "_single_pulse"}, 32'({done, err}), 0);
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_gnt"}, 32'(gnt), 0);
    check({tag, "_pulse"}, 32'({done, err}), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_owner"}, 32'(owner), 0);
    check({tag, "_en"}, 32'(cnt_enable), 0);
    check({tag, "_mode"}, 32'(cnt_mode), 0);
    check({tag, "_d"}, 32'(cnt_d), 0);
  endtask
  initial begin
    tick();
    check_zero("rst");
    reset = 1'b0;
    // single up-count 12 -> 15
    exp_gnt.push_back(0);
    push_end(0, 1'b0, 4);
    drive(0, 4'd12, 1'b1);
    tick();
    check("single_lat_gnt", 32'(gnt), 1);
    check("single_load_mode", 32'(cnt_mode), MODE_LOAD);
    check("single_load_d", 32'(cnt_d), 12);
    check("single_load_en", 32'(cnt_enable), 1);
    tick();
    check("single_run_mode", 32'(cnt_mode), MODE_UP1);
    check("single_run_d", 32'(cnt_d), 0);
    wait_end("single", n);
    req = '0;
    tick();
    check("single_busy_fall", 32'(busy), 0);
    check("single_owner_hold", 32'(owner), 0);
    // contention from a fresh pointer
    reset = 1'b1;
    tick();
    reset = 1'b0;
`ifdef COUNTER_ARB_RR_EN
    order = '{0, 1, 3, 0};
`else
    order = '{0, 0, 0, 0};
`endif
    for (int k = 0; k < 4; k++) begin
      req_d[4*k +: 4] = 4'd14;
      exp_gnt.push_back(order[k]);
      push_end(order[k], 1'b0, 2);
    end
    req_dir = '1;
    req = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      wait_end("cont", n);
      if (k == 3) begin
        req = '0;
        tick();
      end else begin
        tick(2);
        check("cont_back_to_back", 32'(gnt != '0), 1);
      end
    end
    run_one("down", 2, 4'd3, 1'b0, 1'b0, 4);
    check("owner_hold_idle", 32'(owner), 2);
    run_one("zero_up", 0, 4'hF, 1'b1, 1'b0, 1);
    run_one("zero_dn", 3, 4'h0, 1'b0, 1'b0, 1);
    rco_kill = 1'b1;
    run_one("wdog", 1, 4'd5, 1'b1, 1'b1, MAX_RUN);
    rco_kill = 1'b0;
    // abort by dropping req mid-run
    exp_gnt.push_back(1);
    drive(1, 4'd0, 1'b1);
    tick(3);
    req = '0;
    tick();
    check("abort_busy", 32'(busy), 0);
    check("abort_gnt", 32'(gnt), 0);
    check("abort_en", 32'(cnt_enable), 0);
    tick(3);
    // reset while in LOAD, then a normal grant
    exp_gnt.push_back(3);
    drive(3, 4'd13, 1'b1);
    tick();
    check("rl_load_mode", 32'(cnt_mode), MODE_LOAD);
    reset = 1'b1;
    tick();
    check_zero("rl");
    reset = 1'b0;
    run_one("post_rst", 3, 4'd13, 1'b1, 1'b0, 3);
    load_kill = 1'b1;
    run_one("load_to", 2, 4'd7, 1'b1, 1'b1, 0);
    load_kill = 1'b0;
    tick(2);
    check("sb_drain", exp_gnt.size() + exp_end.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
endmodule
